reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_RST, default 3: number of sequenced reset outputs (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 127: cycles to wait after the synchronised PLL lock before the first release (1..65535).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 16: cycles between successive channel releases (1..255).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1024: cycles btn_n must be stable before it is accepted (1..65535).
REQ-005 SHALL have port clock, input, 1: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high block reset.
REQ-007 SHALL have port pll_locked, input, 1: asynchronous PLL lock status, active-high.
REQ-008 SHALL have port btn_n, input, 1: asynchronous pushbutton, active-low.
REQ-009 SHALL have port sw_req, input, 1: synchronous one-cycle software reset request.
REQ-010 SHALL have port rst_out, output, N_RST: active-high domain resets; bit 0 is released first.
REQ-011 SHALL have port ready, output, 1: high when all channels are released.
REQ-012 SHALL have port cause, output, 2: cause of the last sequence (0 reset, 1 lock loss, 2 button, 3 software).

Function
REQ-013 SHALL pass pll_locked and btn_n through 2-flop synchronisers before use; this adds 2 cycles of latency.
REQ-014 SHALL accept a debounced button press only after the synchronised btn_n has been low for DEBOUNCE_CYCLES consecutive cycles; any high sample SHALL clear the debounce count.
REQ-015 SHALL generate one trigger per press; the button SHALL release and be re-debounced before it can trigger again.
REQ-016 SHALL implement the states ASSERT, HOLD, RELEASE and RUN.
REQ-017 ASSERT: rst_out SHALL be all ones and ready SHALL be 0; the block SHALL move to HOLD on the first cycle the synchronised lock is 1.
REQ-018 HOLD: the hold counter SHALL count from 0; at count HOLD_CYCLES-1 the block SHALL move to RELEASE.
REQ-019 RELEASE: in the first RELEASE cycle rst_out[0] SHALL be 0; each rst_out[k] SHALL fall exactly STAGGER_CYCLES cycles after rst_out[k-1]; once released, a bit SHALL stay low until the next trigger.
REQ-020 RUN: entered the cycle after rst_out[N_RST-1] falls; ready SHALL be 1 while in RUN.
REQ-021 A trigger SHALL move the block from any state to ASSERT on the next edge, re-asserting all rst_out bits at once. Triggers are: synchronised lock = 0 outside ASSERT, an accepted button press, or sw_req = 1.
REQ-022 On a trigger, cause SHALL be updated in the same edge; for simultaneous triggers the priority is lock loss > button > software.
REQ-023 A lock loss during HOLD or RELEASE SHALL restart the full sequence; the counters SHALL not be preserved.
REQ-024 sw_req or a button press while already in ASSERT SHALL update cause and have no other effect.
REQ-025 All counters SHALL be sized to their parameter with $clog2 and SHALL not wrap; each saturates or exits at its terminal count.

Reset
REQ-026 While reset is high (sampled on a clock edge), the block SHALL set: state ASSERT, rst_out all ones, ready 0, cause 0, synchronisers 0, and all counters 0.
REQ-027 Reset asserted mid-sequence SHALL take effect on the next edge and SHALL take priority over all triggers.

Structure
REQ-028 The state encoding and the cause codes (CAUSE_RESET, CAUSE_LOCK, CAUSE_BTN, CAUSE_SW) SHALL be defined in the shared package rst_seq_pkg.
REQ-029 The debouncer SHALL be a sub-module named debounce, with input synchronisation, a parameterised stable count, and a one-cycle press pulse output.
REQ-030 The 2-flop synchroniser SHALL be inline; no further hierarchy.

Verification (N_RST=3, HOLD=8, STAGGER=4, DEBOUNCE=4)
REQ-031 Reset high for 4 cycles, then low, with pll_locked=1 held -> rst_out[0] falls 10 cycles after reset goes low, rst_out[1] at 14, rst_out[2] at 18, ready=1 at 19, cause=0.
REQ-032 pll_locked dropped for 1 cycle while in RUN -> rst_out=3'b111 and ready=0 within 3 cycles, cause=1, then a full re-sequence with identical spacing.
REQ-033 btn_n low for 3 cycles -> no effect; btn_n low for 4 or more cycles -> a single re-sequence with cause=2; holding btn_n low for 100 cycles -> no second trigger.
REQ-034 sw_req pulsed in the same cycle the synchronised lock falls -> cause=1; sw_req pulsed alone during RELEASE (after rst_out[0] falls) -> all bits re-asserted next cycle, cause=3.
REQ-035 Reset asserted at HOLD count 5 -> next cycle state ASSERT, counters 0, cause=0; after reset releases, the sequence timing matches REQ-031.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset sequencer.
//   state_t     - sequencer states (ASSERT, HOLD, RELEASE, RUN)
//   cause_t     - cause codes reported on reset_sequencer.cause
//   cnt_width() - counter width helper, never narrower than one bit
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RESET = 2'd0,
        CAUSE_LOCK  = 2'd1,
        CAUSE_BTN   = 2'd2,
        CAUSE_SW    = 2'd3
    } cause_t;

    // Width of a counter that must hold values 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce: synchronises an asynchronous active-low pushbutton and emits a
// single-cycle press pulse once it has been low for STABLE_CYCLES samples.
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset
//   btn_n  - asynchronous pushbutton, active low
//   press  - one-cycle pulse per accepted press
module debounce #(
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] low_cnt;
    // The synchroniser resets to 0 (reads as "pressed"); a press only counts
    // after the button has been seen released at least once.
    logic             armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            low_cnt  <= '0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            btn_meta <= btn_n;
            btn_sync <= btn_meta;
            if (btn_sync) begin
                low_cnt <= '0;
                armed   <= 1'b1;
                press   <= 1'b0;
            end else if (armed && (low_cnt != CNT_W'(STABLE_CYCLES))) begin
                // Saturating at STABLE_CYCLES gives exactly one pulse per press.
                low_cnt <= low_cnt + 1'b1;
                press   <= (low_cnt == CNT_W'(STABLE_CYCLES - 1));
            end else begin
                press   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds N_RST domain resets asserted until the PLL is locked,
// waits HOLD_CYCLES, then releases the channels one by one STAGGER_CYCLES
// apart. Lock loss, a debounced button press or a software request restart
// the sequence.
//   clock      - rising-edge clock
//   reset      - synchronous active-high block reset
//   pll_locked - asynchronous PLL lock status, active high
//   btn_n      - asynchronous pushbutton, active low
//   sw_req     - synchronous one-cycle software reset request
//   rst_out    - active-high domain resets, bit 0 released first
//   ready      - high when all channels are released
//   cause      - cause of the last sequence (reset/lock/button/software)
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_RST           = 3,
    parameter int unsigned HOLD_CYCLES     = 127,
    parameter int unsigned STAGGER_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             btn_n,
    input  logic             sw_req,
    output logic [N_RST-1:0] rst_out,
    output logic             ready,
    output logic [1:0]       cause
);

    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int unsigned STAG_W = cnt_width(STAGGER_CYCLES);
    localparam int unsigned IDX_W  = cnt_width(N_RST);

    logic lock_meta;
    logic lock_sync;
    logic btn_press;

    state_t            state_q, state_d;
    cause_t            cause_q, cause_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [STAG_W-1:0] stag_q, stag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic lock_lost;
    logic trigger;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .btn_n(btn_n),
        .press(btn_press)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_ASSERT;
            cause_q <= CAUSE_RESET;
            hold_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        hold_d    = hold_q;
        stag_d    = stag_q;
        idx_d     = idx_q;
        lock_lost = !lock_sync && (state_q != ST_ASSERT);
        trigger   = lock_lost || btn_press || sw_req;

        case (state_q)
            ST_ASSERT: begin
                if (lock_sync) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    stag_d  = '0;
                    idx_d   = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // idx_q is the highest channel already released; once the
                // last one is down, RUN follows on the next edge.
                if (idx_q == IDX_W'(N_RST - 1)) begin
                    state_d = ST_RUN;
                end else if (stag_q == STAG_W'(STAGGER_CYCLES - 1)) begin
                    stag_d = '0;
                    idx_d  = idx_q + 1'b1;
                end else begin
                    stag_d = stag_q + 1'b1;
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (trigger) begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            stag_d  = '0;
            idx_d   = '0;
            if (lock_lost) begin
                cause_d = CAUSE_LOCK;
            end else if (btn_press) begin
                cause_d = CAUSE_BTN;
            end else begin
                cause_d = CAUSE_SW;
            end
        end
    end

    always_comb begin
        rst_out = '1;
        ready   = 1'b0;
        case (state_q)
            ST_RELEASE: begin
                for (int unsigned k = 0; k < N_RST; k++) begin
                    if (IDX_W'(k) <= idx_q) begin
                        rst_out[k] = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                rst_out = '0;
                ready   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cause = cause_q;

endmodule
